reg_share_arbiter: RTL

Round-robin arbiter and write controller that lets NREQ requesters share one WIDTH-bit register built from D flip-flops with asynchronous reset. A requester requests ownership, receives a registered one-hot grant, performs zero or more writes while it owns the register, then releases it. A hold timeout stops any one requester from starving the others. It sits between several producer blocks and a shared status/data register.

---
 rtl/reg_share_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/reg_share_arbiter.sv
// Round-robin ownership arbiter in front of one shared WIDTH-bit register.
// The owner may write while it holds the grant; a hold timeout bounds ownership.
module reg_share_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4,
    parameter int IDXW     = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       wr_en,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [IDXW-1:0]       owner,
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid,
    output logic [0:0]            dbg_state
);

    localparam int HOLDW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLDW-1:0] HOLD_MAX = HOLDW'(MAX_HOLD);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    // Handshake: req is a level; gnt is registered and one-hot while owned.
    // A write is accepted only on an edge where the owner holds both req and wr_en.
    logic [0:0]       r_state;
    logic [IDXW-1:0]  r_ptr;
    logic [HOLDW-1:0] r_hold;
    logic [NREQ-1:0]  r_gnt;
    logic [IDXW-1:0]  r_owner;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;

    logic [WIDTH-1:0] w_slice [NREQ];
    logic [WIDTH-1:0] w_owner_data;
    logic             w_owner_req;
    logic             w_owner_wr;
    logic             w_timeout;
    logic [IDXW-1:0]  w_next_ptr;
    logic             w_found;
    logic [IDXW-1:0]  w_win;
    logic [IDXW:0]    w_sum;
    logic [IDXW-1:0]  w_cand;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign w_slice[gi] = wdata[gi*WIDTH +: WIDTH];
    end

    assign w_owner_data = w_slice[r_owner];
    assign w_owner_req  = req[r_owner];
    assign w_owner_wr   = wr_en[r_owner];
    assign w_timeout    = (MAX_HOLD != 0) && (r_hold == HOLD_MAX);
    assign w_next_ptr   = (r_owner == IDXW'(NREQ - 1)) ? '0 : r_owner + IDXW'(1);

    // Search starts at r_ptr and wraps modulo NREQ (NREQ need not be a power of two).
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IDXW+1)'(k);
            if (w_sum >= (IDXW+1)'(NREQ)) begin
                w_sum = w_sum - (IDXW+1)'(NREQ);
            end
            w_cand = w_sum[IDXW-1:0];
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_gnt     <= '0;
            r_owner   <= '0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
                        r_owner <= w_win;
                        r_hold  <= HOLDW'(1);
                        r_state <= ST_OWNED;
                    end
                end
                ST_OWNED: begin
                    if (!w_owner_req) begin
                        r_gnt   <= '0;
                        r_ptr   <= w_next_ptr;
                        r_state <= ST_IDLE;
                    end else begin
                        if (w_owner_wr) begin
                            r_q       <= w_owner_data;
                            r_q_valid <= 1'b1;
                        end
                        // The write on the timeout edge still lands before the grant drops.
                        if (w_timeout) begin
                            r_gnt   <= '0;
                            r_ptr   <= w_next_ptr;
                            r_state <= ST_IDLE;
                        end else if (r_hold < HOLD_MAX) begin
                            r_hold <= r_hold + HOLDW'(1);
                        end
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign owner     = r_owner;
    assign q         = r_q;
    assign q_valid   = r_q_valid;
    assign dbg_state = r_state;

endmodule
